// File: rtl/inc_rr_scheduler.sv
// Round-robin scheduler that merges N queued event sources onto one registered increment strobe.
// Optional INC_SCHED_STATS_EN adds a saturating 16-bit count of dropped events on port lost.
module inc_rr_scheduler #(
    parameter int N  = 4,
    parameter int PW = 4,
    parameter int W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N-1:0]         ev,
    input  logic                 ovf_clr,
    output logic                 inc,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic [W-1:0]         cnt,
    output logic [N-1:0]         pend_nz,
`ifdef INC_SCHED_STATS_EN
    output logic [15:0]          lost,
`endif
    output logic [N-1:0]         ovf
);
    localparam int IW = $clog2(N);
    localparam logic [PW-1:0] PMAX = {PW{1'b1}};

    logic [N-1:0]  cand;
    logic [N-1:0]  drop;
    logic          gnt;
    logic [IW-1:0] sel;
    logic [IW-1:0] ptr_reg;
    logic [IW-1:0] ptr_next;
    logic          inc_reg;
    logic [IW-1:0] gnt_id_reg;
    logic [W-1:0]  cnt_reg;
    logic [N-1:0]  ovf_reg;

    // Search ptr, ptr+1, ... mod N; iterating backwards lets the nearest candidate win.
    always_comb begin
        int idx;
        idx = 0;
        gnt = 1'b0;
        sel = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr_reg) + k) % N;
            if (cand[idx]) begin
                gnt = 1'b1;
                sel = IW'(idx);
            end
        end
    end

    assign ptr_next = (sel == IW'(N - 1)) ? '0 : sel + IW'(1);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_src
            logic [PW-1:0] pend_reg;
            logic          served;

            assign served      = gnt && (sel == IW'(gi));
            assign cand[gi]    = en && (pend_reg != '0);
            assign pend_nz[gi] = (pend_reg != '0);
            // An event arriving while this source is served replaces the one drained, so it never overflows.
            assign drop[gi]    = ev[gi] && !served && (pend_reg == PMAX);

            always_ff @(posedge clk) begin
                if (rst) begin
                    pend_reg <= '0;
                end else if (ev[gi] && !served && (pend_reg != PMAX)) begin
                    pend_reg <= pend_reg + PW'(1);
                end else if (!ev[gi] && served) begin
                    pend_reg <= pend_reg - PW'(1);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg    <= '0;
            inc_reg    <= 1'b0;
            gnt_id_reg <= '0;
            cnt_reg    <= '0;
            ovf_reg    <= '0;
        end else begin
            inc_reg <= gnt;
            cnt_reg <= cnt_reg + W'(gnt);
            if (gnt) begin
                gnt_id_reg <= sel;
                ptr_reg    <= ptr_next;
            end
            ovf_reg <= (ovf_clr ? '0 : ovf_reg) | drop;
        end
    end

    assign inc    = inc_reg;
    assign gnt_id = gnt_id_reg;
    assign cnt    = cnt_reg;
    assign ovf    = ovf_reg;

`ifdef INC_SCHED_STATS_EN
    logic [4:0]  drop_cnt;
    logic [16:0] lost_sum;
    logic [15:0] lost_reg;
    logic [15:0] lost_next;

    // Clear is applied before this cycle's drops are added, then the sum saturates.
    always_comb begin
        drop_cnt = '0;
        for (int i = 0; i < N; i++) begin
            drop_cnt = drop_cnt + 5'(drop[i]);
        end
        lost_sum  = (ovf_clr ? 17'd0 : {1'b0, lost_reg}) + 17'(drop_cnt);
        lost_next = lost_sum[16] ? 16'hFFFF : lost_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lost_reg <= '0;
        end else begin
            lost_reg <= lost_next;
        end
    end

    assign lost = lost_reg;
`endif
endmodule
